// File: rtl/riscv_csr_counters_pkg.sv
// ---------------------------------------------------------------------------
// riscv_csr_counters_pkg
// Shared constants for the user-level counter CSR unit:
//   - SYSTEM opcode and the CSR funct3 encodings
//   - CSRAddress enum of the CSR codes the core knows about
//   - COUNTER_WIDTH of the cycle/time/instret counters
//   - helpers classifying a funct3 as a CSR op and as a write attempt
// ---------------------------------------------------------------------------
package riscv_csr_counters_pkg;

    localparam int COUNTER_WIDTH = 64;

    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

    typedef enum logic [11:0] {
        CSR_FFLAGS   = 12'h001,
        CSR_FRM      = 12'h002,
        CSR_FCSR     = 12'h003,
        CSR_CYCLE    = 12'hC00,
        CSR_TIME     = 12'hC01,
        CSR_INSTRET  = 12'hC02,
        CSR_CYCLEH   = 12'hC80,
        CSR_TIMEH    = 12'hC81,
        CSR_INSTRETH = 12'hC82
    } CSRAddress;

    // funct3 values 000 and 100 are not CSR instructions at all.
    function automatic logic funct3_is_csr(input logic [2:0] funct3);
        return funct3[1:0] != 2'b00;
    endfunction

    // CSRRW/CSRRWI always write; set/clear forms write only with a non-zero source.
    function automatic logic funct3_writes(input logic [2:0] funct3, input logic src_zero);
        logic writes;
        writes = 1'b0;
        case (funct3)
            FUNCT3_CSRRW, FUNCT3_CSRRWI:                 writes = 1'b1;
            FUNCT3_CSRRS, FUNCT3_CSRRC,
            FUNCT3_CSRRSI, FUNCT3_CSRRCI:                writes = !src_zero;
            default:                                     writes = 1'b0;
        endcase
        return writes;
    endfunction

endpackage

// File: rtl/riscv_csr_counters_if.sv
// ---------------------------------------------------------------------------
// riscv_csr_counters_if
// Request/response bundle between the execute stage and the counter CSR unit.
//   csr_valid/csr_funct3/csr_addr/csr_src_zero : decoded CSR instruction
//   instr_retired                              : retire pulse
//   csr_rdata/csr_rdata_valid/csr_illegal      : registered response
// master = pipeline side, slave = counter unit.
// ---------------------------------------------------------------------------
interface riscv_csr_counters_if;

    logic        csr_valid;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic        csr_src_zero;
    logic        instr_retired;
    logic [31:0] csr_rdata;
    logic        csr_rdata_valid;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_funct3, csr_addr, csr_src_zero, instr_retired,
        input  csr_rdata, csr_rdata_valid, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_funct3, csr_addr, csr_src_zero, instr_retired,
        output csr_rdata, csr_rdata_valid, csr_illegal
    );

endinterface

// File: rtl/riscv_counter64.sv
// ---------------------------------------------------------------------------
// riscv_counter64
// Free-running wrap-around counter used for cycle, time and instret.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one on this edge
//   value : current count (wraps silently from all ones to zero)
// ---------------------------------------------------------------------------
module riscv_counter64
    import riscv_csr_counters_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    output logic [COUNTER_WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc) begin
            value <= value + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/riscv_csr_counters.sv
// ---------------------------------------------------------------------------
// riscv_csr_counters
// Read-only user counter CSRs (cycle/time/instret and their high halves).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : riscv_csr_counters_if.slave request/response bundle
// Parameters:
//   TIME_DIV      : clock cycles per time tick (1..65535)
//   COUNTER_WIDTH : counter width, always 64
// A request sampled on an edge is answered in the following cycle with the
// counter value as it was before that edge's increment.
// ---------------------------------------------------------------------------
module riscv_csr_counters #(
    parameter int TIME_DIV      = 100,
    parameter int COUNTER_WIDTH = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    riscv_csr_counters_if.slave bus
);

    import riscv_csr_counters_pkg::*;

    localparam logic [15:0] PRESCALE_LAST = 16'(TIME_DIV - 1);

    logic [COUNTER_WIDTH-1:0] cycle_value;
    logic [COUNTER_WIDTH-1:0] time_value;
    logic [COUNTER_WIDTH-1:0] instret_value;

    logic [15:0] prescaler;
    logic        time_tick;

    logic        req_fire;
    logic [31:0] req_rdata;
    logic        req_addr_ok;
    logic        req_illegal;

    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        illegal_q;

    // Prescaler wraps at TIME_DIV-1; with TIME_DIV=1 it stays at 0 and ticks every edge.
    assign time_tick = (prescaler == PRESCALE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (time_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    riscv_counter64 u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .value (cycle_value)
    );

    riscv_counter64 u_time (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (time_tick),
        .value (time_value)
    );

    riscv_counter64 u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.instr_retired),
        .value (instret_value)
    );

    assign req_fire = bus.csr_valid && funct3_is_csr(bus.csr_funct3);

    // Decode reads the counters combinationally so the registered response
    // captures the pre-increment value; unknown addresses (including the
    // floating-point CSRs) read as zero and are flagged illegal.
    always_comb begin
        req_rdata   = '0;
        req_addr_ok = 1'b1;
        case (bus.csr_addr)
            CSR_CYCLE:    req_rdata = cycle_value[31:0];
            CSR_CYCLEH:   req_rdata = cycle_value[63:32];
            CSR_TIME:     req_rdata = time_value[31:0];
            CSR_TIMEH:    req_rdata = time_value[63:32];
            CSR_INSTRET:  req_rdata = instret_value[31:0];
            CSR_INSTRETH: req_rdata = instret_value[63:32];
            default:      req_addr_ok = 1'b0;
        endcase
        req_illegal = !req_addr_ok || funct3_writes(bus.csr_funct3, bus.csr_src_zero);
    end

    // rdata holds between responses; the illegal flag only accompanies a valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            rdata_valid_q <= req_fire;
            illegal_q     <= req_fire && req_illegal;
            if (req_fire) begin
                rdata_q <= req_rdata;
            end
        end
    end

    assign bus.csr_rdata       = rdata_q;
    assign bus.csr_rdata_valid = rdata_valid_q;
    assign bus.csr_illegal     = illegal_q;

endmodule

// File: tb/tb_riscv_csr_counters.sv
// ---------------------------------------------------------------------------
// tb_riscv_csr_counters
// Scoreboard bench for riscv_csr_counters with TIME_DIV=4: stimulus pushes
// the expected response, a negedge monitor pops it when the unit answers.
// ---------------------------------------------------------------------------
module tb_riscv_csr_counters;

    localparam int TB_TIME_DIV = 4;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [63:0] edge_count;
    exp_t exp_q[$];

    riscv_csr_counters_if bus ();

    riscv_csr_counters #(
        .TIME_DIV      (TB_TIME_DIV),
        .COUNTER_WIDTH (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count <= '0;
        end else begin
            edge_count <= edge_count + 64'd1;
        end
    end

    // Monitor: every valid response consumes the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.csr_rdata_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_response got rdata=%h illegal=%b with nothing expected",
                         bus.csr_rdata, bus.csr_illegal);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.csr_rdata !== e.rdata || bus.csr_illegal !== e.illegal) begin
                    failures++;
                    $display("[TB] FAIL %s got rdata=%h illegal=%b expected rdata=%h illegal=%b",
                             e.name, bus.csr_rdata, bus.csr_illegal, e.rdata, e.illegal);
                end
            end
        end
    end

    // Drive one request cycle (called just after a rising edge) and queue its expectation.
    task automatic applyStimulus(input string name, input logic [2:0] funct3,
                                 input logic [11:0] addr, input logic src_zero,
                                 input logic retire, input logic expect_resp,
                                 input logic [31:0] exp_rdata, input logic exp_illegal);
        exp_t e;
        bus.csr_valid     = 1'b1;
        bus.csr_funct3    = funct3;
        bus.csr_addr      = addr;
        bus.csr_src_zero  = src_zero;
        bus.instr_retired = retire;
        if (expect_resp) begin
            e.name    = name;
            e.rdata   = exp_rdata;
            e.illegal = exp_illegal;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.csr_valid     = 1'b0;
        bus.instr_retired = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic retire(input int n);
        bus.instr_retired = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.instr_retired = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.csr_valid     = 1'b0;
        bus.csr_funct3    = 3'b000;
        bus.csr_addr      = 12'h000;
        bus.csr_src_zero  = 1'b1;
        bus.instr_retired = 1'b0;

        // Reset state.
        #12;
        checkOutput("reset_rdata",   bus.csr_rdata, 32'd0);
        checkOutput("reset_valid",   32'(bus.csr_rdata_valid), 32'd0);
        checkOutput("reset_illegal", 32'(bus.csr_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cycle reads: first edge after release, then ten edges later.
        applyStimulus("cycle_first_edge", 3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        idle(9);
        applyStimulus("cycle_edge11", 3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, 32'd10, 1'b0);

        // Time with TIME_DIV=4: ticks at edges 4, 8, 12.
        applyStimulus("time_edge12", 3'b010, 12'hC01, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0);
        applyStimulus("time_edge13", 3'b010, 12'hC01, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0);

        // Instret after five retire pulses, high half, and same-edge read.
        retire(5);
        applyStimulus("instret_5",       3'b010, 12'hC02, 1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
        applyStimulus("instreth_0",      3'b010, 12'hC82, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("instret_same_ed", 3'b010, 12'hC02, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0);
        applyStimulus("instret_6",       3'b010, 12'hC02, 1'b1, 1'b0, 1'b1, 32'd6, 1'b0);

        // Legality decode.
        applyStimulus("csrrw_cycle",     3'b001, 12'hC00, 1'b1, 1'b0, 1'b1, edge_count[31:0], 1'b1);
        applyStimulus("csrrs_cycle",     3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, edge_count[31:0], 1'b0);
        applyStimulus("csrrs_nz_cycle",  3'b010, 12'hC00, 1'b0, 1'b0, 1'b1, edge_count[31:0], 1'b1);
        applyStimulus("csrrc_timeh",     3'b011, 12'hC81, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("csrrsi_nz_inst",  3'b110, 12'hC02, 1'b0, 1'b0, 1'b1, 32'd6, 1'b1);
        applyStimulus("csrrsi_time",     3'b110, 12'hC01, 1'b1, 1'b0, 1'b1,
                      32'(edge_count / TB_TIME_DIV), 1'b0);
        applyStimulus("csrrci_insth",    3'b111, 12'hC82, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("csrrwi_cycleh",   3'b101, 12'hC80, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
        applyStimulus("addr_fflags",     3'b010, 12'h001, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
        applyStimulus("addr_fcsr",       3'b010, 12'h003, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
        applyStimulus("addr_hpm3",       3'b010, 12'hC03, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
        applyStimulus("f3_000", 3'b000, 12'hC00, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("f3_000_valid",   32'(bus.csr_rdata_valid), 32'd0);
        checkOutput("f3_000_illegal", 32'(bus.csr_illegal), 32'd0);
        applyStimulus("f3_100", 3'b100, 12'hC00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("f3_100_valid",   32'(bus.csr_rdata_valid), 32'd0);
        checkOutput("f3_100_illegal", 32'(bus.csr_illegal), 32'd0);

        // Carry from low to high half and full 64-bit wrap via preload.
        force dut.u_cycle.value = 64'h0000_0000_FFFF_FFFF;
        release dut.u_cycle.value;
        idle(1);
        applyStimulus("carry_lo", 3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("carry_hi", 3'b010, 12'hC80, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0);
        force dut.u_cycle.value = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.u_cycle.value;
        idle(1);
        applyStimulus("wrap_lo", 3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("wrap_hi", 3'b010, 12'hC80, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);

        // Asynchronous reset while a response is showing and another request is pending.
        bus.csr_valid    = 1'b1;
        bus.csr_funct3   = 3'b001;
        bus.csr_addr     = 12'hC00;
        bus.csr_src_zero = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_valid",   32'(bus.csr_rdata_valid), 32'd1);
        checkOutput("pre_reset_illegal", 32'(bus.csr_illegal), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rdata",   bus.csr_rdata, 32'd0);
        checkOutput("async_rst_valid",   32'(bus.csr_rdata_valid), 32'd0);
        checkOutput("async_rst_illegal", 32'(bus.csr_illegal), 32'd0);
        bus.csr_valid = 1'b0;
        idle(2);
        checkOutput("in_reset_valid", 32'(bus.csr_rdata_valid), 32'd0);
        rst_n = 1'b1;
        applyStimulus("post_rst_cycle",    3'b010, 12'hC00, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("post_rst_instret",  3'b010, 12'hC02, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("post_rst_time",     3'b010, 12'hC01, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("post_rst_timeh",    3'b010, 12'hC81, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("post_rst_instreth", 3'b010, 12'hC82, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);
        applyStimulus("post_rst_cycleh",   3'b010, 12'hC80, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0);

        // Every queued expectation must be consumed within a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_queue got %0d outstanding responses expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
